// File: rtl/issue_unit_pkg.sv
// Shared types for the issue stage: issue-latch states, latched instruction payload,
// and a register-index helper.
package issue_unit_pkg;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HELD  = 1'b1;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] addr;
        logic        branch;
        logic        ls;
        logic        use_imm;
        logic        jalr;
    } inst_t;

    // x0 is hardwired: it is never renamed and always reads as a ready zero.
    function automatic logic reads_reg(input logic [4:0] idx);
        return idx != 5'd0;
    endfunction

endpackage

// File: rtl/issue_unit_operand_resolver.sv
// Resolves one source operand from register status, ROB readout and (with
// ISSUE_CDB_BYPASS_EN defined) the CDB broadcast into value / tag / ready.
module operand_resolver
    import issue_unit_pkg::*;
#(
    parameter int ROB_W = 3
) (
`ifdef ISSUE_CDB_BYPASS_EN
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_val,
`endif
    input  logic [4:0]       idx,
    input  logic             busy,
    input  logic [ROB_W-1:0] tag,
    input  logic [31:0]      reg_val,
    input  logic             rob_ready,
    input  logic [31:0]      rob_val,
    output logic [31:0]      v,
    output logic [ROB_W-1:0] q,
    output logic             ready
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        v     = '0;
        q     = '0;
        ready = 1'b1;
        if (reads_reg(idx)) begin
            if (!busy) begin
                v = reg_val;
            end else if (rob_ready) begin
                v = rob_val;
            end
`ifdef ISSUE_CDB_BYPASS_EN
            else if (cdb_valid && cdb_tag == tag) begin
                v = cdb_val;
            end
`endif
            else begin
                q     = tag;
                ready = 1'b0;
            end
        end
    end

endmodule

// File: rtl/issue_unit.sv
// Issue stage: single-entry issue latch between the fetched-op queue and RS/LSB dispatch.
// Define ISSUE_CDB_BYPASS_EN to forward the CDB into operands instead of stalling on it.
module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int ROB_W = 3
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             predict_fail_in,
    input  logic             inst_valid_in,
    input  logic [4:0]       op_in,
    input  logic [4:0]       rd_in,
    input  logic [4:0]       rs1_in,
    input  logic [4:0]       rs2_in,
    input  logic [31:0]      imm_in,
    input  logic             branch_in,
    input  logic             ls_in,
    input  logic             use_imm_in,
    input  logic             jalr_in,
    input  logic [31:0]      addr_in,
    output logic             pop_out,
    output logic [4:0]       reg_rs1_out,
    output logic [4:0]       reg_rs2_out,
    input  logic [31:0]      reg_val1_in,
    input  logic [31:0]      reg_val2_in,
    input  logic             reg_busy1_in,
    input  logic             reg_busy2_in,
    input  logic [ROB_W-1:0] reg_tag1_in,
    input  logic [ROB_W-1:0] reg_tag2_in,
    output logic [ROB_W-1:0] rob_q1_tag_out,
    output logic [ROB_W-1:0] rob_q2_tag_out,
    input  logic             rob_q1_ready_in,
    input  logic             rob_q2_ready_in,
    input  logic [31:0]      rob_q1_val_in,
    input  logic [31:0]      rob_q2_val_in,
    input  logic             cdb_valid_in,
    input  logic [ROB_W-1:0] cdb_tag_in,
    input  logic [31:0]      cdb_val_in,
    input  logic             rob_full_in,
    input  logic             rs_full_in,
    input  logic             lsb_full_in,
    input  logic [ROB_W-1:0] rob_tail_tag_in,
    output logic             rob_alloc_out,
    output logic             rs_we_out,
    output logic             lsb_we_out,
    output logic             rename_we_out,
    output logic [4:0]       d_op_out,
    output logic [4:0]       d_rd_out,
    output logic [31:0]      d_imm_out,
    output logic [31:0]      d_addr_out,
    output logic             d_branch_out,
    output logic             d_jalr_out,
    output logic             d_use_imm_out,
    output logic [31:0]      d_vj_out,
    output logic [31:0]      d_vk_out,
    output logic [ROB_W-1:0] d_qj_out,
    output logic [ROB_W-1:0] d_qk_out,
    output logic             d_rj_out,
    output logic             d_rk_out,
    output logic [ROB_W-1:0] d_tag_out
);

    logic [0:0]       state;
    inst_t            inst;
    logic             held, active, cdb_stall, unit_full, can_dispatch, dispatch;
    logic [31:0]      vj, vk;
    logic [ROB_W-1:0] qj, qk;
    logic             rj, rk;

    assign held = (state == ST_HELD);

    operand_resolver #(.ROB_W(ROB_W)) u_src1 (
`ifdef ISSUE_CDB_BYPASS_EN
        .cdb_valid (cdb_valid_in),
        .cdb_tag   (cdb_tag_in),
        .cdb_val   (cdb_val_in),
`endif
        .idx       (inst.rs1),
        .busy      (reg_busy1_in),
        .tag       (reg_tag1_in),
        .reg_val   (reg_val1_in),
        .rob_ready (rob_q1_ready_in),
        .rob_val   (rob_q1_val_in),
        .v         (vj),
        .q         (qj),
        .ready     (rj)
    );

    operand_resolver #(.ROB_W(ROB_W)) u_src2 (
`ifdef ISSUE_CDB_BYPASS_EN
        .cdb_valid (cdb_valid_in),
        .cdb_tag   (cdb_tag_in),
        .cdb_val   (cdb_val_in),
`endif
        .idx       (inst.rs2),
        .busy      (reg_busy2_in),
        .tag       (reg_tag2_in),
        .reg_val   (reg_val2_in),
        .rob_ready (rob_q2_ready_in),
        .rob_val   (rob_q2_val_in),
        .v         (vk),
        .q         (qk),
        .ready     (rk)
    );

`ifdef ISSUE_CDB_BYPASS_EN
    assign cdb_stall = 1'b0;
`else
    // A source waiting on the tag broadcast right now would miss it; the ROB shows it ready next cycle.
    assign cdb_stall = cdb_valid_in && ((!rj && qj == cdb_tag_in) || (!rk && qk == cdb_tag_in));

    logic unused_cdb_val;
    assign unused_cdb_val = ^cdb_val_in;
`endif

    // Reset is folded in so pop and dispatch strobes drop the moment rst_n_in falls.
    assign active       = rst_n_in && rdy_in && !predict_fail_in;
    assign unit_full    = inst.ls ? lsb_full_in : rs_full_in;
    assign can_dispatch = held && !rob_full_in && !unit_full && !cdb_stall;
    assign dispatch     = active && can_dispatch;
    assign pop_out      = active && inst_valid_in && (!held || can_dispatch);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        // NOTE: sequential state uses non-blocking assignments only; the payload is reset too so every bundle field reads 0 out of reset.
        if (!rst_n_in) begin
            state <= ST_EMPTY;
            inst  <= '0;
        end else if (rdy_in) begin
            if (predict_fail_in) begin
                state <= ST_EMPTY;
            end else if (pop_out) begin
                state <= ST_HELD;
                inst  <= '{op: op_in, rd: rd_in, rs1: rs1_in, rs2: rs2_in, imm: imm_in,
                           addr: addr_in, branch: branch_in, ls: ls_in,
                           use_imm: use_imm_in, jalr: jalr_in};
            end else if (dispatch) begin
                state <= ST_EMPTY;
            end
        end
    end

    assign rob_alloc_out  = dispatch;
    assign rs_we_out      = dispatch && !inst.ls;
    assign lsb_we_out     = dispatch && inst.ls;
    assign rename_we_out  = dispatch && reads_reg(inst.rd);
    assign reg_rs1_out    = inst.rs1;
    assign reg_rs2_out    = inst.rs2;
    assign rob_q1_tag_out = reg_tag1_in;
    assign rob_q2_tag_out = reg_tag2_in;

    always_comb begin
        d_op_out      = '0;
        d_rd_out      = '0;
        d_imm_out     = '0;
        d_addr_out    = '0;
        d_branch_out  = 1'b0;
        d_jalr_out    = 1'b0;
        d_use_imm_out = 1'b0;
        d_vj_out      = '0;
        d_vk_out      = '0;
        d_qj_out      = '0;
        d_qk_out      = '0;
        d_rj_out      = 1'b0;
        d_rk_out      = 1'b0;
        d_tag_out     = '0;
        if (held) begin
            d_op_out      = inst.op;
            d_rd_out      = inst.rd;
            d_imm_out     = inst.imm;
            d_addr_out    = inst.addr;
            d_branch_out  = inst.branch;
            d_jalr_out    = inst.jalr;
            d_use_imm_out = inst.use_imm;
            d_vj_out      = vj;
            d_vk_out      = vk;
            d_qj_out      = qj;
            d_qk_out      = qk;
            d_rj_out      = rj;
            d_rk_out      = rk;
            d_tag_out     = rob_tail_tag_in;
        end
    end

endmodule

// File: tb/tb_issue_unit.sv
// Self-checking bench for issue_unit: directed scenarios with literal expectations,
// then randomized traffic against a behavioural model of the issue latch.
module tb_issue_unit;

    localparam int ROB_W = 3;

    typedef struct packed {
        logic [4:0]  op, rd, rs1, rs2;
        logic [31:0] imm, addr;
        logic        branch, ls, use_imm, jalr;
    } inst_t;

    typedef struct {
        logic [31:0]      v;
        logic [ROB_W-1:0] q;
        logic             r;
    } res_t;

    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic rdy, pf, ivalid;
    inst_t head;
    logic [31:0] val1, val2, rv1, rv2, cdb_val;
    logic busy1, busy2, rq1, rq2, cdb_valid, rob_full, rs_full, lsb_full;
    logic [ROB_W-1:0] tag1, tag2, cdb_tag, tail;

    logic pop_out, rob_alloc_out, rs_we_out, lsb_we_out, rename_we_out;
    logic [4:0] reg_rs1_out, reg_rs2_out, d_op_out, d_rd_out;
    logic [ROB_W-1:0] rob_q1_tag_out, rob_q2_tag_out, d_qj_out, d_qk_out, d_tag_out;
    logic [31:0] d_imm_out, d_addr_out, d_vj_out, d_vk_out;
    logic d_branch_out, d_jalr_out, d_use_imm_out, d_rj_out, d_rk_out;

    issue_unit #(.ROB_W(ROB_W)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy), .predict_fail_in(pf),
        .inst_valid_in(ivalid), .op_in(head.op), .rd_in(head.rd), .rs1_in(head.rs1),
        .rs2_in(head.rs2), .imm_in(head.imm), .branch_in(head.branch), .ls_in(head.ls),
        .use_imm_in(head.use_imm), .jalr_in(head.jalr), .addr_in(head.addr),
        .pop_out(pop_out), .reg_rs1_out(reg_rs1_out), .reg_rs2_out(reg_rs2_out),
        .reg_val1_in(val1), .reg_val2_in(val2), .reg_busy1_in(busy1), .reg_busy2_in(busy2),
        .reg_tag1_in(tag1), .reg_tag2_in(tag2), .rob_q1_tag_out(rob_q1_tag_out),
        .rob_q2_tag_out(rob_q2_tag_out), .rob_q1_ready_in(rq1), .rob_q2_ready_in(rq2),
        .rob_q1_val_in(rv1), .rob_q2_val_in(rv2), .cdb_valid_in(cdb_valid),
        .cdb_tag_in(cdb_tag), .cdb_val_in(cdb_val), .rob_full_in(rob_full),
        .rs_full_in(rs_full), .lsb_full_in(lsb_full), .rob_tail_tag_in(tail),
        .rob_alloc_out(rob_alloc_out), .rs_we_out(rs_we_out), .lsb_we_out(lsb_we_out),
        .rename_we_out(rename_we_out), .d_op_out(d_op_out), .d_rd_out(d_rd_out),
        .d_imm_out(d_imm_out), .d_addr_out(d_addr_out), .d_branch_out(d_branch_out),
        .d_jalr_out(d_jalr_out), .d_use_imm_out(d_use_imm_out), .d_vj_out(d_vj_out),
        .d_vk_out(d_vk_out), .d_qj_out(d_qj_out), .d_qk_out(d_qk_out),
        .d_rj_out(d_rj_out), .d_rk_out(d_rk_out), .d_tag_out(d_tag_out)
    );

    int total = 0;
    int bad = 0;

    // Model: whether the issue latch holds an instruction, and which one.
    logic  m_held = 1'b0;
    inst_t m_inst = '0;
    logic  m_pop;

    // Last sampled DUT values, for the directed literal checks.
    logic s_pop, s_alloc, s_rs, s_lsb, s_ren, s_rj;
    logic [ROB_W-1:0] s_tag;
    logic [31:0] s_vj;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t resolve(input logic [4:0] idx, input logic busy,
                                     input logic [ROB_W-1:0] tag, input logic [31:0] val,
                                     input logic rq, input logic [31:0] rv);
        res_t o;
        o.v = 32'd0; o.q = tag; o.r = 1'b0;
        if (idx == 5'd0) begin o.r = 1'b1; end
        else if (!busy) begin o.v = val; o.r = 1'b1; end
        else if (rq) begin o.v = rv; o.r = 1'b1; end
`ifdef ISSUE_CDB_BYPASS_EN
        else if (cdb_valid && cdb_tag == tag) begin o.v = cdb_val; o.r = 1'b1; end
`endif
        return o;
    endfunction

    function automatic inst_t rand_inst();
        inst_t i;
        i.op = 5'($urandom); i.rd = 5'($urandom % 8); i.rs1 = 5'($urandom % 8);
        i.rs2 = 5'($urandom % 8); i.imm = $urandom; i.addr = $urandom;
        i.branch = ($urandom % 4) == 0; i.ls = ($urandom % 3) == 0;
        i.use_imm = 1'($urandom); i.jalr = ($urandom % 8) == 0;
        return i;
    endfunction

    function automatic inst_t mk(input logic [4:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic ls);
        inst_t i = rand_inst();
        i.op = op; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.ls = ls;
        if (ls) begin i.branch = 1'b0; i.jalr = 1'b0; end
        return i;
    endfunction

    task automatic quiet_env();
        rdy = 1'b1; pf = 1'b0; ivalid = 1'b0;
        busy1 = 1'b0; busy2 = 1'b0; tag1 = '0; tag2 = '0;
        val1 = $urandom; val2 = $urandom; rq1 = 1'b0; rq2 = 1'b0; rv1 = $urandom; rv2 = $urandom;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    endtask

    task automatic random_env();
        rdy = ($urandom % 10) != 0; pf = ($urandom % 25) == 0; ivalid = ($urandom % 5) != 0;
        busy1 = 1'($urandom); busy2 = 1'($urandom);
        tag1 = ROB_W'($urandom); tag2 = ROB_W'($urandom);
        val1 = $urandom; val2 = $urandom;
        rq1 = ($urandom % 3) == 0; rq2 = ($urandom % 3) == 0; rv1 = $urandom; rv2 = $urandom;
        cdb_valid = 1'($urandom); cdb_val = $urandom;
        cdb_tag = ($urandom % 2) ? tag1 : (($urandom % 2) ? tag2 : ROB_W'($urandom));
        rob_full = ($urandom % 10) == 0; rs_full = ($urandom % 7) == 0; lsb_full = ($urandom % 7) == 0;
    endtask

    // Entered one time unit after a rising edge with inputs already driven; leaves at the same
    // point of the following cycle after advancing the model across the edge.
    task automatic step();
        res_t ej, ek;
        logic stall, cd, ed;
        #3;
        ej = resolve(m_inst.rs1, busy1, tag1, val1, rq1, rv1);
        ek = resolve(m_inst.rs2, busy2, tag2, val2, rq2, rv2);
`ifdef ISSUE_CDB_BYPASS_EN
        stall = 1'b0;
`else
        stall = cdb_valid && ((!ej.r && ej.q == cdb_tag) || (!ek.r && ek.q == cdb_tag));
`endif
        cd    = m_held && !rob_full && !(m_inst.ls ? lsb_full : rs_full) && !stall;
        m_pop = rdy && !pf && ivalid && (!m_held || cd);
        ed    = rdy && !pf && cd;
        check("strobes", {pop_out, rob_alloc_out, rs_we_out, lsb_we_out, rename_we_out},
              {m_pop, ed, ed && !m_inst.ls, ed && m_inst.ls, ed && m_inst.rd != 5'd0});
        check("rob_q_tags", {rob_q1_tag_out, rob_q2_tag_out}, {tag1, tag2});
        if (m_held) begin
            check("reg_idx", {reg_rs1_out, reg_rs2_out}, {m_inst.rs1, m_inst.rs2});
            check("bundle", {d_op_out, d_rd_out, d_imm_out, d_addr_out, d_branch_out,
                             d_jalr_out, d_use_imm_out, d_tag_out},
                  {m_inst.op, m_inst.rd, m_inst.imm, m_inst.addr, m_inst.branch,
                   m_inst.jalr, m_inst.use_imm, tail});
            check("src1", {d_vj_out, d_rj_out, d_rj_out ? {ROB_W{1'b0}} : d_qj_out},
                  {ej.v, ej.r, ej.r ? {ROB_W{1'b0}} : ej.q});
            check("src2", {d_vk_out, d_rk_out, d_rk_out ? {ROB_W{1'b0}} : d_qk_out},
                  {ek.v, ek.r, ek.r ? {ROB_W{1'b0}} : ek.q});
        end
        s_pop = pop_out; s_alloc = rob_alloc_out; s_rs = rs_we_out; s_lsb = lsb_we_out;
        s_ren = rename_we_out; s_rj = d_rj_out; s_vj = d_vj_out; s_tag = d_tag_out;
        @(posedge clk_in);
        if (rdy) begin
            if (pf) m_held = 1'b0;
            else if (m_pop) begin m_held = 1'b1; m_inst = head; end
            else if (ed) m_held = 1'b0;
        end
        if (ed) tail = tail + 1'b1;
        #1;
    endtask

    initial begin
        logic [4:0]  pops, rsw;
        logic [11:0] tags;
        logic [2:0]  stalls;

        quiet_env();
        ivalid = 1'b1;
        head = mk(5'd1, 5'd2, 5'd3, 5'd4, 1'b0);
        tail = '0;
        #2;
        check("reset_strobes", {pop_out, rob_alloc_out, rs_we_out, lsb_we_out, rename_we_out,
                                reg_rs1_out, reg_rs2_out, rob_q1_tag_out, rob_q2_tag_out}, '0);
        check("reset_bundle", {d_op_out, d_rd_out, d_imm_out, d_addr_out, d_branch_out,
                               d_jalr_out, d_use_imm_out, d_tag_out}, '0);
        check("reset_operands", {d_vj_out, d_vk_out, d_qj_out, d_qk_out, d_rj_out, d_rk_out}, '0);
        ivalid = 1'b0;
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;

        // Four independent ALU ops back to back.
        pops = '0; rsw = '0; tags = '0;
        for (int i = 0; i < 5; i++) begin
            ivalid = (i < 4);
            head = mk(5'(i), 5'(10 + i), 5'(i + 1), 5'(i + 1), 1'b0);
            step();
            pops = {pops[3:0], s_pop};
            rsw  = {rsw[3:0], s_rs};
            if (s_rs) tags = {tags[8:0], s_tag};
        end
        check("stream_pops", pops, 5'b11110);
        check("stream_rs_we", rsw, 5'b01111);
        check("stream_tags", tags, {3'd0, 3'd1, 3'd2, 3'd3});

        // Load held back by a full LSB for three cycles.
        quiet_env();
        head = mk(5'd3, 5'd6, 5'd2, 5'd0, 1'b1); ivalid = 1'b1;
        step();
        head = mk(5'd7, 5'd8, 5'd1, 5'd2, 1'b0); lsb_full = 1'b1; stalls = '0;
        repeat (3) begin
            step();
            stalls = {stalls[1:0], s_pop | s_lsb};
        end
        check("lsb_full_stall", stalls, 3'b000);
        lsb_full = 1'b0;
        step();
        check("lsb_release", {s_lsb, s_pop}, 2'b11);
        ivalid = 1'b0;
        step();

        // rs1 = x5 waiting on tag 2 while the CDB broadcasts tag 2.
        quiet_env();
        head = mk(5'd4, 5'd7, 5'd5, 5'd0, 1'b0); ivalid = 1'b1;
        step();
        ivalid = 1'b0; busy1 = 1'b1; tag1 = 3'd2; rq1 = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_val = 32'hDEAD;
        step();
`ifdef ISSUE_CDB_BYPASS_EN
        check("cdb_bypass", {s_rs, s_rj, s_vj}, {1'b1, 1'b1, 32'hDEAD});
`else
        check("cdb_stall", {s_rs, s_alloc}, 2'b00);
        cdb_valid = 1'b0; rq1 = 1'b1; rv1 = 32'hDEAD;
        step();
        check("rob_after_stall", {s_rs, s_rj, s_vj}, {1'b1, 1'b1, 32'hDEAD});
`endif

        // Flush while held with a valid head waiting.
        quiet_env();
        head = mk(5'd9, 5'd3, 5'd1, 5'd0, 1'b0); ivalid = 1'b1;
        step();
        head = mk(5'd10, 5'd4, 5'd2, 5'd0, 1'b0); rob_full = 1'b1;
        step();
        pf = 1'b1;
        step();
        check("flush", {s_pop, s_alloc, s_rs, s_lsb, s_ren}, 5'b0);
        pf = 1'b0; rob_full = 1'b0;
        step();
        check("post_flush_pop", {s_pop, s_alloc}, 2'b10);
        ivalid = 1'b0;
        step();
        check("post_flush_dispatch", {s_alloc, s_rs}, 2'b11);

        // x0 as destination and source.
        quiet_env();
        head = mk(5'd1, 5'd0, 5'd0, 5'd0, 1'b0); ivalid = 1'b1;
        step();
        ivalid = 1'b0; busy1 = 1'b1; busy2 = 1'b1; tag1 = 3'd1; val1 = 32'h1234;
        step();
        check("x0", {s_alloc, s_ren, s_rj, s_vj}, {1'b1, 1'b0, 1'b1, 32'd0});

        // Asynchronous reset while a dispatch is pending.
        quiet_env();
        head = mk(5'd2, 5'd9, 5'd1, 5'd2, 1'b0); ivalid = 1'b1;
        step();
        #1 rst_n_in = 1'b0;
        #1;
        check("async_reset", {pop_out, rob_alloc_out, rs_we_out, lsb_we_out}, 4'b0);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1; m_held = 1'b0; ivalid = 1'b0;
        step();
        check("no_dispatch_after_reset", {s_alloc, s_rs, s_lsb}, 3'b0);

        // Randomized traffic; a new head appears only once the current one is popped.
        head = rand_inst();
        for (int n = 0; n < 3000; n++) begin
            random_env();
            step();
            if (m_pop) head = rand_inst();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_unit.md
# issue_unit

Issue stage of the out-of-order core. Pops one decoded instruction per cycle from the fetched-op queue's head, holds it in a single-entry issue latch, resolves both source operands against register status, ROB and CDB, and dispatches it in one step: ROB entry allocation, rd rename, and entry into either the reservation station (RS) or the load/store buffer (LSB). It is the consumer end of the fetched-op queue's valid/success handshake.

## Interface
- ROB_W, default 3: ROB tag width; 2^ROB_W ROB entries.
- clk_in  in  1  clock; all state changes on the rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global ready; low pauses the block, with no pop, no dispatch and state held.
- predict_fail_in  in  1  flush.
- inst_valid_in  in  1  queue head is valid.
- op_in[5], rd_in[5], rs1_in[5], rs2_in[5], imm_in[32], branch_in, ls_in, use_imm_in, jalr_in, addr_in[32]  in  queue head fields.
- pop_out  out  1  head is consumed this cycle; drives the queue's launch-success input.
- reg_rs1_out, reg_rs2_out  out  5  register file / register status read indices.
- reg_val1_in, reg_val2_in  in  32; reg_busy1_in, reg_busy2_in  in  1; reg_tag1_in, reg_tag2_in  in  ROB_W.
- rob_q1_tag_out, rob_q2_tag_out  out  ROB_W; rob_q1_ready_in, rob_q2_ready_in  in  1; rob_q1_val_in, rob_q2_val_in  in  32.
- cdb_valid_in  in  1; cdb_tag_in  in  ROB_W; cdb_val_in  in  32.
- rob_full_in, rs_full_in, lsb_full_in  in  1.
- rob_tail_tag_in  in  ROB_W  tag that the next allocation receives.
- rob_alloc_out  out  1; rs_we_out, lsb_we_out  out  1; rename_we_out  out  1.
- d_op_out[5], d_rd_out[5], d_imm_out[32], d_addr_out[32], d_branch_out, d_jalr_out, d_use_imm_out  out  dispatch bundle.
- d_vj_out, d_vk_out  out  32; d_qj_out, d_qk_out  out  ROB_W; d_rj_out, d_rk_out  out  1 (1 = operand ready); d_tag_out  out  ROB_W.

## Operation
- Issue latch states: EMPTY, HELD.
- can_dispatch = HELD && !rob_full_in && !(ls ? lsb_full_in : rs_full_in) && !cdb_stall.
- pop_out = rdy_in && !predict_fail_in && inst_valid_in && (EMPTY || can_dispatch). A pop loads the latch, which is then HELD.
- EMPTY→HELD on pop. HELD→EMPTY on a dispatch with no pop. HELD→HELD on a pop and dispatch in the same cycle, or on a stall.
- Dispatch cycle: rob_alloc_out = 1. lsb_we_out = ls, rs_we_out = !ls. Branch and jalr go to the RS.
- Dispatch cycle: d_tag_out = rob_tail_tag_in. rename_we_out = (rd != 0).
- Operand resolution, per source, first match wins:
  - index 0 → value 0, ready.
  - !reg_busy → reg_val.
  - rob_q_ready for reg_tag → rob_q_val.
  - CDB match (cdb_valid_in && cdb_tag_in == reg_tag) → cdb_val_in.
  - otherwise not ready: q = reg_tag, v = 0.
- rob_q*_tag_out = reg_tag*_in.
- The fetch side zeroes rs1/rs2 of formats that do not read them.
- use_imm_in does not suppress rs2 resolution; the RS/LSB picks the operand.
- predict_fail_in: the latch goes EMPTY at the edge. pop_out and all dispatch strobes are 0 that cycle.
- rdy_in low: all strobes are 0 and the latch is held.
- Reset: latch EMPTY; every output is 0, including pop_out, all strobes and every bundle field.

## Timing
- Head present in cycle t with room available → popped at edge t → dispatch strobes in cycle t+1 → consumers capture at edge t+1.
- Sustained throughput is one instruction per cycle.
- Dispatch outputs are combinational from the latch plus the lookups. They are stable only while HELD.
- A rename written at edge t is visible through reg_busy in cycle t+1. Back-to-back dependents therefore see the correct tag.

## Configuration
- ISSUE_CDB_BYPASS_EN defined: the CDB forwarding path is compiled in, and cdb_stall = 0.
- ISSUE_CDB_BYPASS_EN undefined: no CDB forwarding. cdb_stall = 1 whenever a source is pending on a tag equal to cdb_tag_in while cdb_valid_in is high. The latch waits one cycle, and the ROB then reports the source ready. This prevents a dispatched entry from missing its broadcast.

## Structure
- Shared `src/macros.v`: ROB size and width macros, op encodings, dispatch bundle width.
- Sub-module operand_resolver: one source's index, busy, tag, value, ROB and CDB inputs → v/q/ready outputs. Instantiated twice.

## Test plan
- Reset mid-HELD: rst_n_in low asynchronously → pop_out, rob_alloc_out, rs_we_out and lsb_we_out are 0 immediately, and no dispatch follows.
- Stream of 4 independent ALU ops with x1..x4 not busy → pops in 4 consecutive cycles, 4 consecutive rs_we_out, d_tag_out 0,1,2,3.
- Load with lsb_full_in = 1 for 3 cycles → no dispatch and pop_out = 0 while HELD; lsb_we_out on the cycle lsb_full_in falls.
- rs1 = x5 busy with tag 2, ROB not ready, CDB {tag 2, 0xDEAD} in the dispatch cycle:
  - with ISSUE_CDB_BYPASS_EN → d_rj_out = 1, d_vj_out = 0xDEAD.
  - without → one-cycle stall, then the ROB value is used.
- predict_fail_in while HELD and the head is valid → latch EMPTY, no strobes, pop_out = 0; the next head issues normally.
- rd = x0 → rename_we_out = 0; rs1 = x0 → d_rj_out = 1, d_vj_out = 0.
